// File: rtl/byte_to_sample_unpack_pkg.sv
// Shared definitions for the byte-to-sample unpacker: legal symbol widths,
// symbols-per-byte derivation, FIFO sizing helpers and the unpacker state type.
package byte_to_sample_unpack_pkg;

   // Unpacker states: EMPTY = no byte loaded, SHIFT = byte loaded and being emitted.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_SHIFT = 1'b1
   } unpack_state_t;

   // Symbol index width; enough for up to 8 symbols per byte.
   localparam int unsigned IT_W = 3;

   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned MIN_FIFO_DEPTH = 2;
   localparam int unsigned MAX_FIFO_DEPTH = 16;

   // Symbol widths must divide a byte evenly.
   function automatic bit nblsb_legal(input int n);
      return (n == 1) || (n == 2) || (n == 4) || (n == 8);
   endfunction

   // Number of symbols carried by one byte.
   function automatic int nbit_of(input int n);
      return 8 / n;
   endfunction

   // FIFO depth must be a power of two so pointers wrap naturally.
   function automatic bit depth_legal(input int d);
      return (d >= MIN_FIFO_DEPTH) && (d <= MAX_FIFO_DEPTH) && ((d & (d - 1)) == 0);
   endfunction

   // Pointer width indexes DEPTH entries.
   function automatic int ptr_w(input int d);
      return $clog2(d);
   endfunction

   // Level width must also represent the full count DEPTH.
   function automatic int level_w(input int d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/byte_to_sample_unpack_fifo.sv
// Small synchronous byte FIFO with level, full and empty outputs.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module byte_fifo
   import byte_to_sample_unpack_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_push,
   input  logic [7:0]                  i_data,
   input  logic                        i_pop,
   output logic [7:0]                  o_data,
   output logic                        o_push_ok,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [level_w(DEPTH)-1:0]   o_level
);

   localparam int PW = ptr_w(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_full;
   logic          w_empty;
   logic          w_wr_en;
   logic          w_rd_en;

   assign w_full    = (r_level == LW'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_rd_en   = i_pop && !w_empty;
   assign w_wr_en   = i_push && (!w_full || w_rd_en);

   assign o_data    = r_mem[r_rd_ptr];
   assign o_push_ok = w_wr_en;
   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_level   = r_level;

   // Storage write; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and level bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/byte_to_sample_unpack.sv
// Unpacks UART bytes into NBLSB-bit symbols, LSB first, through a byte FIFO.
// Handshake: a sample moves when sample_valid and sample_ready are both high
// at a rising edge; while sample_valid is high and sample_ready low, sample
// and sample_valid hold. rx_valid is a one-cycle strobe with no back-pressure:
// a byte arriving with no FIFO room is dropped and flagged in overflow.
module byte_to_sample_unpack
   import byte_to_sample_unpack_pkg::*;
#(
   parameter int NBLSB      = 1,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [7:0]                       rx_byte,
   input  logic                             rx_valid,
   input  logic                             sample_ready,
   input  logic                             clr_ovf,
   output logic [7:0]                       sample,
   output logic                             sample_valid,
   output logic                             overflow,
   output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level,
   output logic                             dbg_state
);

   localparam int         NBIT     = nbit_of(NBLSB);
   localparam logic [7:0] SYM_MASK = 8'((1 << NBLSB) - 1);

   if (!nblsb_legal(NBLSB)) begin : g_bad_nblsb
      $error("byte_to_sample_unpack: NBLSB must be 1, 2, 4 or 8");
   end
   if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
      $error("byte_to_sample_unpack: FIFO_DEPTH must be a power of two in 2..16");
   end

   unpack_state_t   r_state;
   logic [IT_W-1:0] r_it;
   logic [7:0]      r_shift;
   logic            r_valid;
   logic            r_ovf;

   logic [7:0]      w_fifo_data;
   logic            w_push_ok;
   logic            w_full;
   logic            w_empty;
   logic            w_xfer;
   logic            w_last;
   logic            w_pop;

   assign w_xfer = r_valid && sample_ready;
   assign w_last = (r_it == IT_W'(NBIT - 1));
   // Pop when idle, or when the last symbol leaves so the next byte follows without a bubble.
   assign w_pop  = !w_empty && ((r_state == ST_EMPTY) || (w_xfer && w_last));

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (rx_valid),
      .i_data    (rx_byte),
      .i_pop     (w_pop),
      .o_data    (w_fifo_data),
      .o_push_ok (w_push_ok),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (fifo_level)
   );

   // Unpacker FSM: load a byte, then shift one symbol out per transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_it    <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (!w_empty) begin
                  r_state <= ST_SHIFT;
                  r_it    <= '0;
                  r_shift <= w_fifo_data;
                  r_valid <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_xfer) begin
                  if (!w_last) begin
                     r_it    <= r_it + IT_W'(1);
                     r_shift <= r_shift >> NBLSB;
                  end else if (!w_empty) begin
                     r_it    <= '0;
                     r_shift <= w_fifo_data;
                  end else begin
                     r_state <= ST_EMPTY;
                     r_it    <= '0;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_EMPTY;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow: a dropped byte wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (rx_valid && !w_push_ok) begin
         r_ovf <= 1'b1;
      end else if (clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   assign sample       = r_shift & SYM_MASK;
   assign sample_valid = r_valid;
   assign overflow     = r_ovf;
   assign dbg_state    = r_state;

   logic w_unused;
   assign w_unused = w_full;

endmodule
